ps2_key_event_gen: RTL

//  Transmit end of the ps2_key[10:0] toggle-event protocol that the core's keyboard decoders consume.

---
 rtl/ps2_evt_pkg.sv | 22 ++
 rtl/ps2_evt_prio_enc.sv | 23 ++
 rtl/ps2_key_event_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/ps2_evt_pkg.sv
// Shared constants for the ps2_key toggle-event protocol: field positions, key type
// and the scancodes commonly mapped onto joystick buttons.
package ps2_evt_pkg;

    localparam int PS2_TOGGLE  = 10;
    localparam int PS2_PRESSED = 9;
    localparam int PS2_EXT     = 8;

    typedef logic [10:0] ps2_key_t;

    // {ext, scancode}
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_LCTRL = 9'h014;
    localparam logic [8:0] KEY_F1    = 9'h005;
    localparam logic [8:0] KEY_F2    = 9'h006;
    localparam logic [8:0] KEY_5     = 9'h02E;

endpackage

// File: rtl/ps2_evt_prio_enc.sv
// Combinational lowest-set-bit encoder; valid is 0 when no request is set.
module ps2_evt_prio_enc #(
    parameter int N_BTN = 16,
    parameter int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic [N_BTN-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_gen.sv
// Turns a level bitmap of buttons into a paced stream of ps2_key toggle events,
// one event per reported state change, lowest button index first.
module ps2_key_event_gen
    import ps2_evt_pkg::*;
#(
    parameter int                 N_BTN      = 16,
    parameter logic [N_BTN*9-1:0] KEYMAP     = '0,
    parameter int                 GAP_CYCLES = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_BTN-1:0] btn_in,
    output ps2_key_t         ps2_key,
    output logic             busy,
    output logic [7:0]       ev_count
);

    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES);

    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] rep;
    logic [N_BTN-1:0] rep_nxt;
    logic [N_BTN-1:0] pending;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nxt;
    ps2_key_t         key_nxt;
    logic [7:0]       cnt_nxt;
    logic             busy_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             sel_lvl;
    logic [8:0]       sel_code;
    logic             emit;

    assign pending = btn_q ^ rep;

    ps2_evt_prio_enc #(
        .N_BTN(N_BTN),
        .IDX_W(IDX_W)
    ) u_prio (
        .req  (pending),
        .idx  (sel_idx),
        .valid(sel_valid)
    );

    assign emit = enable && (gap == '0) && sel_valid;

    always_comb begin
        sel_lvl  = 1'b0;
        sel_code = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_lvl  = btn_q[i];
                sel_code = KEYMAP[i*9 +: 9];
            end
        end
    end

    always_comb begin
        rep_nxt = rep;
        gap_nxt = (gap != '0) ? gap - GAP_W'(1) : gap;
        key_nxt = ps2_key;
        cnt_nxt = ev_count;
        if (emit) begin
            key_nxt = {~ps2_key[PS2_TOGGLE], sel_lvl, sel_code};
            for (int i = 0; i < N_BTN; i++) begin
                if (IDX_W'(i) == sel_idx) begin
                    rep_nxt[i] = sel_lvl;
                end
            end
            gap_nxt = GAP_W'(GAP_CYCLES - 1);
            cnt_nxt = ev_count + 8'd1;
        end
        // busy describes the state being loaded on this edge, so it is built from next values.
        busy_nxt = (|(btn_in ^ rep_nxt)) || (gap_nxt != '0);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_q    <= '0;
            rep      <= '0;
            gap      <= '0;
            ps2_key  <= '0;
            ev_count <= '0;
            busy     <= 1'b0;
        end else begin
            btn_q    <= btn_in;
            rep      <= rep_nxt;
            gap      <= gap_nxt;
            ps2_key  <= key_nxt;
            ev_count <= cnt_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
